// File: rtl/fpu_req_arbiter_pkg.sv
// fpu_arb_pkg: shared types and constants for the FPU request arbiter.
//   - arb_state_e : arbiter FSM states
//   - OP_*        : fpu_op encodings that matter to the arbiter
//   - FLAG_*      : bit positions inside the 8-bit exception flag word
//   - fpu_cmd_t   : operation payload held stable at the FPU inputs
//   - op_latency  : settle time for a given fpu_op
package fpu_arb_pkg;

  localparam int unsigned FLAG_W = 8;

  // Flag word layout: {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf}
  localparam int unsigned FLAG_INF  = 0;
  localparam int unsigned FLAG_SNAN = 1;
  localparam int unsigned FLAG_QNAN = 2;
  localparam int unsigned FLAG_INE  = 3;
  localparam int unsigned FLAG_OVF  = 4;
  localparam int unsigned FLAG_UNF  = 5;
  localparam int unsigned FLAG_ZERO = 6;
  localparam int unsigned FLAG_DZ   = 7;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned RMODE_W = 2;
  localparam int unsigned DATA_W  = 32;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [RMODE_W-1:0] rmode;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
  } fpu_cmd_t;

  // Divide is the only long operation; every other code (including 4..7) uses fpu_lat.
  function automatic int unsigned op_latency(input logic [OP_W-1:0] op,
                                             input int unsigned fpu_lat,
                                             input int unsigned div_lat);
    return (op == OP_DIV) ? div_lat : fpu_lat;
  endfunction

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// fpu_req_arbiter_if: client-side request/response channels of the FPU arbiter.
//   req_valid/req_ready   per-requester request handshake
//   req_op/rmode/opa/opb  per-requester packed payloads (3/2/32/32 bits each)
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_out/rsp_flags     shared result and exception flags
// Modports: master = requesters, slave = arbiter.
interface fpu_req_arbiter_if
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [OP_W*NUM_REQ-1:0]    req_op;
  logic [RMODE_W*NUM_REQ-1:0] req_rmode;
  logic [DATA_W*NUM_REQ-1:0]  req_opa;
  logic [DATA_W*NUM_REQ-1:0]  req_opb;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [DATA_W-1:0]          rsp_out;
  logic [FLAG_W-1:0]          rsp_flags;

  modport master (
    output req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_flags
  );

endinterface

// File: rtl/fpu_req_arbiter_rr.sv
// fpu_rr_arbiter: combinational round-robin pick.
//   req  : request vector
//   ptr  : highest-priority index this cycle (held by the parent)
//   gnt  : one-hot grant, zero when no request
//   idx  : encoded index of the grant
module fpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic [NUM_REQ-1:0] at_or_above;
  logic [NUM_REQ-1:0] req_hi;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    at_or_above = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      at_or_above[i] = (PTR_W'(i) >= ptr);
    end
    req_hi = req & at_or_above;

    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = PTR_W'(i);
    end
    if (|req_hi) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_hi[i]) idx = PTR_W'(i);
      end
    end

    gnt = (|req) ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one FPU among NUM_REQ requesters, one op in flight.
//   clk, rst       clock, asynchronous active-low reset
//   cli (slave)    client request/response channels (fpu_req_arbiter_if)
//   fpu_op/rmode/opa/opb  registered operands, held until the next issue
//   fpu_out/flags  FPU result, captured when the op latency has elapsed
//   busy           high whenever the FSM is not IDLE
// Optional (FPU_ARB_STICKY_FLAGS_EN): flag_clr / sticky_flags per-requester
// accumulated exception flags.
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FPU_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic                clk,
  input  logic                rst,
  fpu_req_arbiter_if.slave    cli,
  output logic [OP_W-1:0]     fpu_op,
  output logic [RMODE_W-1:0]  fpu_rmode,
  output logic [DATA_W-1:0]   fpu_opa,
  output logic [DATA_W-1:0]   fpu_opb,
  input  logic [DATA_W-1:0]   fpu_out,
  input  logic [FLAG_W-1:0]   fpu_flags,
  output logic                busy
`ifdef FPU_ARB_STICKY_FLAGS_EN
  ,
  input  logic [NUM_REQ-1:0]        flag_clr,
  output logic [FLAG_W*NUM_REQ-1:0] sticky_flags
`endif
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned MAX_LAT = (FPU_LAT > DIV_LAT) ? FPU_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  arb_state_e          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    owner;
  logic [CNT_W-1:0]    cnt;
  fpu_cmd_t            cmd_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_out_q;
  logic [FLAG_W-1:0]   rsp_flags_q;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  fpu_cmd_t            sel_cmd;
  logic [NUM_REQ-1:0]  rsp_hs_vec;
  logic                rsp_hs;

  // Requests are only visible to the arbiter in IDLE, so req_ready is zero elsewhere.
  assign arb_req = (state == IDLE) ? cli.req_valid : '0;

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign cli.req_ready = gnt;

  // Payload of the granted requester.
  always_comb begin
    sel_cmd.op    = cli.req_op[32'(gnt_idx)*OP_W +: OP_W];
    sel_cmd.rmode = cli.req_rmode[32'(gnt_idx)*RMODE_W +: RMODE_W];
    sel_cmd.opa   = cli.req_opa[32'(gnt_idx)*DATA_W +: DATA_W];
    sel_cmd.opb   = cli.req_opb[32'(gnt_idx)*DATA_W +: DATA_W];
  end

  // rsp_valid_q is one-hot on the owner, so masking ignores non-owner rsp_ready.
  assign rsp_hs_vec = rsp_valid_q & cli.rsp_ready;
  assign rsp_hs     = |rsp_hs_vec;

  // Arbiter FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            cmd_q <= sel_cmd;
            owner <= gnt_idx;
            ptr   <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            cnt   <= CNT_W'(op_latency(sel_cmd.op, FPU_LAT, DIV_LAT) - 1);
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        // Operands reach the FPU this cycle; counting starts in WAIT.
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_out_q   <= fpu_out;
            rsp_flags_q <= fpu_flags;
            rsp_valid_q <= NUM_REQ'(1) << owner;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cli.rsp_valid = rsp_valid_q;
  assign cli.rsp_out   = rsp_out_q;
  assign cli.rsp_flags = rsp_flags_q;

  assign fpu_op    = cmd_q.op;
  assign fpu_rmode = cmd_q.rmode;
  assign fpu_opa   = cmd_q.opa;
  assign fpu_opb   = cmd_q.opb;

`ifdef FPU_ARB_STICKY_FLAGS_EN
  // Per-requester flag accumulation; a clear coinciding with a handshake keeps the new flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flag_clr[i]) begin
          sticky_flags[i*FLAG_W +: FLAG_W] <= rsp_hs_vec[i] ? rsp_flags_q : '0;
        end else if (rsp_hs_vec[i]) begin
          sticky_flags[i*FLAG_W +: FLAG_W] <= sticky_flags[i*FLAG_W +: FLAG_W] | rsp_flags_q;
        end
      end
    end
  end
`endif

endmodule
